// File: rtl/lidar_uart_distance_pkg.sv
// Shared constants and types for the lidar scan-frame receiver and its mean divider.
package lidar_uart_distance_pkg;

    localparam logic [7:0] HDR0_DEF = 8'h55;
    localparam logic [7:0] HDR1_DEF = 8'hAA;

    localparam int DIVIDEND_W = 24;
    localparam int DIVISOR_W  = 8;
    localparam int QUOT_W     = 16;

    typedef enum logic [2:0] {
        IDLE_WAIT_HIGH,
        IDLE,
        HDR,
        LSN,
        DATA
    } rx_state_e;

endpackage

// File: rtl/lidar_uart_distance_udiv24_8.sv
// Restoring unsigned 24/8 divider, one quotient bit per clock, MSB first.
// done rises 24 cycles after the accepted start cycle; start while busy is dropped.
module udiv24_8
    import lidar_uart_distance_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic [QUOT_W-1:0]     quotient_o,
    output logic                  done_o
);

    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [4:0]            cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DIVIDEND_W-1:0] src_quo;
    logic [DIVISOR_W-1:0]  src_rem;
    logic [DIVISOR_W-1:0]  src_dvs;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W:0]    diff;
    logic                  qbit;

    // The first iteration runs in the start cycle itself so that 24 bits finish on time.
    always_comb begin
        src_quo = busy_q ? quo_q : dividend_i;
        src_rem = busy_q ? rem_q : '0;
        src_dvs = busy_q ? dvs_q : divisor_i;
        trial   = {src_rem, src_quo[DIVIDEND_W-1]};
        diff    = trial - {1'b0, src_dvs};
        qbit    = (trial >= {1'b0, src_dvs});

        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (busy_q || start_i) begin
            quo_d = {src_quo[DIVIDEND_W-2:0], qbit};
            rem_d = qbit ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
        end

        if (busy_q) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(DIVIDEND_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start_i) begin
            dvs_d  = divisor_i;
            cnt_d  = 5'd1;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient_o = ((dvs_q == '0) || (quo_q[DIVIDEND_W-1:QUOT_W] != '0))
                        ? {QUOT_W{1'b1}} : quo_q[QUOT_W-1:0];
    assign done_o     = done_q;

endmodule

// File: rtl/lidar_uart_distance.sv
// Serial scan-frame receiver: header check, sample count, 16-bit samples -> min/max/mean.
// Byte strobes one cycle after the last bit; frame results when the mean divider completes.
module lidar_uart_distance
    import lidar_uart_distance_pkg::*;
#(
    parameter logic [7:0] HDR0 = HDR0_DEF,
    parameter logic [7:0] HDR1 = HDR1_DEF
)(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rxd_i,
    output logic [7:0]  byte_data_o,
    output logic        byte_valid_o,
    output logic [15:0] dist_min_o,
    output logic [15:0] dist_max_o,
    output logic [15:0] dist_mean_o,
    output logic        frame_done_o
);

    rx_state_e   st_q, st_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  sh_q, sh_d;
    logic        hdr_idx_q, hdr_idx_d;
    logic        hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] min_q, min_d;
    logic [15:0] max_q, max_d;
    logic [23:0] sum_q, sum_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic        byte_vld_q, byte_vld_d;
    logic        div_start_q, div_start_d;
    logic [15:0] pend_min_q, pend_min_d;
    logic [15:0] pend_max_q, pend_max_d;
    logic [15:0] out_min_q, out_min_d;
    logic [15:0] out_max_q, out_max_d;
    logic [15:0] out_mean_q, out_mean_d;

    logic [7:0]  byte_w;
    logic [15:0] sample_w;
    logic        byte_end;
    logic [15:0] div_quot;
    logic        div_done;

    always_comb begin
        byte_w   = {rxd_i, sh_q};
        sample_w = {byte_w, lo_q};
        byte_end = (bit_cnt_q == 3'd7);

        st_d        = st_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        hdr_idx_d   = hdr_idx_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        min_d       = min_q;
        max_d       = max_q;
        sum_d       = sum_q;
        byte_data_d = byte_data_q;
        byte_vld_d  = 1'b0;
        div_start_d = 1'b0;
        pend_min_d  = pend_min_q;
        pend_max_d  = pend_max_q;
        out_min_d   = out_min_q;
        out_max_d   = out_max_q;
        out_mean_d  = out_mean_q;

        if (st_q inside {HDR, LSN, DATA}) begin
            sh_d      = byte_w[7:1];
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        case (st_q)
            IDLE_WAIT_HIGH: begin
                if (rxd_i) st_d = IDLE;
            end
            IDLE: begin
                if (!rxd_i) begin
                    st_d      = HDR;
                    bit_cnt_d = '0;
                    hdr_idx_d = 1'b0;
                end
            end
            HDR: begin
                if (byte_end) begin
                    if (byte_w != (hdr_idx_q ? HDR1 : HDR0)) begin
                        st_d = IDLE_WAIT_HIGH;
                    end else if (!hdr_idx_q) begin
                        hdr_idx_d = 1'b1;
                    end else begin
                        st_d  = LSN;
                        min_d = 16'hFFFF;
                        max_d = '0;
                        sum_d = '0;
                        cnt_d = '0;
                    end
                end
            end
            LSN: begin
                if (byte_end) begin
                    byte_data_d = byte_w;
                    byte_vld_d  = 1'b1;
                    n_d         = byte_w;
                    hi_d        = 1'b0;
                    st_d        = (byte_w == '0) ? IDLE_WAIT_HIGH : DATA;
                end
            end
            DATA: begin
                if (byte_end) begin
                    byte_data_d = byte_w;
                    byte_vld_d  = 1'b1;
                    if (!hi_q) begin
                        lo_d = byte_w;
                        hi_d = 1'b1;
                    end else begin
                        hi_d  = 1'b0;
                        min_d = (sample_w < min_q) ? sample_w : min_q;
                        max_d = (sample_w > max_q) ? sample_w : max_q;
                        sum_d = sum_q + 24'(sample_w);
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == n_q) begin
                            st_d        = IDLE_WAIT_HIGH;
                            div_start_d = 1'b1;
                        end
                    end
                end
            end
            default: st_d = IDLE_WAIT_HIGH;
        endcase

        // Snapshot extremes at divider launch; the receiver may already be on the next frame.
        if (div_start_q) begin
            pend_min_d = min_q;
            pend_max_d = max_q;
        end

        if (div_done) begin
            out_min_d  = pend_min_q;
            out_max_d  = pend_max_q;
            out_mean_d = div_quot;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            st_q        <= IDLE_WAIT_HIGH;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            hdr_idx_q   <= 1'b0;
            hi_q        <= 1'b0;
            lo_q        <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            min_q       <= 16'hFFFF;
            max_q       <= '0;
            sum_q       <= '0;
            byte_data_q <= '0;
            byte_vld_q  <= 1'b0;
            div_start_q <= 1'b0;
            pend_min_q  <= '0;
            pend_max_q  <= '0;
            out_min_q   <= '0;
            out_max_q   <= '0;
            out_mean_q  <= '0;
        end else begin
            st_q        <= st_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            hdr_idx_q   <= hdr_idx_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            min_q       <= min_d;
            max_q       <= max_d;
            sum_q       <= sum_d;
            byte_data_q <= byte_data_d;
            byte_vld_q  <= byte_vld_d;
            div_start_q <= div_start_d;
            pend_min_q  <= pend_min_d;
            pend_max_q  <= pend_max_d;
            out_min_q   <= out_min_d;
            out_max_q   <= out_max_d;
            out_mean_q  <= out_mean_d;
        end
    end

    udiv24_8 u_div (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (div_start_q),
        .dividend_i (sum_q),
        .divisor_i  (n_q),
        .quotient_o (div_quot),
        .done_o     (div_done)
    );

    // Results appear in the very cycle frame_done is high, then hold in the output registers.
    assign byte_data_o  = byte_data_q;
    assign byte_valid_o = byte_vld_q;
    assign dist_min_o   = div_done ? pend_min_q : out_min_q;
    assign dist_max_o   = div_done ? pend_max_q : out_max_q;
    assign dist_mean_o  = div_done ? div_quot   : out_mean_q;
    assign frame_done_o = div_done;

endmodule

// File: tb/tb_lidar_uart_distance.sv
// Scoreboard bench for lidar_uart_distance plus a standalone check of its divider.
module tb_lidar_uart_distance;
    import lidar_uart_distance_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rxd = 1'b1;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [15:0] dist_min, dist_max, dist_mean;
    logic        frame_done;

    logic        d_start = 1'b0;
    logic [23:0] d_dividend = '0;
    logic [7:0]  d_divisor = '0;
    logic [15:0] d_quot;
    logic        d_done;

    typedef struct {
        logic [15:0] mn;
        logic [15:0] mx;
        logic [15:0] mean;
        int          due;
    } frame_t;

    typedef struct {
        logic [15:0] q;
        int          due;
    } div_t;

    logic [7:0]  exp_bytes[$];
    frame_t      exp_frames[$];
    div_t        exp_divs[$];
    logic [15:0] smp[$];
    logic [15:0] last_min = '0, last_max = '0, last_mean = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lidar_uart_distance dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .rxd_i        (rxd),
        .byte_data_o  (byte_data),
        .byte_valid_o (byte_valid),
        .dist_min_o   (dist_min),
        .dist_max_o   (dist_max),
        .dist_mean_o  (dist_mean),
        .frame_done_o (frame_done)
    );

    udiv24_8 u_div_tb (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (d_start),
        .dividend_i (d_dividend),
        .divisor_i  (d_divisor),
        .quotient_o (d_quot),
        .done_o     (d_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: output seen, none required", name);
    endtask

    // Monitor: every DUT output event pops the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (byte_valid) begin
                if (exp_bytes.size() == 0) flag("byte_unexpected");
                else check("byte_data", 32'(byte_data), 32'(exp_bytes.pop_front()));
            end
            if (frame_done) begin
                if (exp_frames.size() == 0) flag("frame_unexpected");
                else begin
                    frame_t f;
                    f = exp_frames.pop_front();
                    check("dist_min", 32'(dist_min), 32'(f.mn));
                    check("dist_max", 32'(dist_max), 32'(f.mx));
                    check("dist_mean", 32'(dist_mean), 32'(f.mean));
                    check("frame_latency", cyc, f.due);
                    last_min  = f.mn;
                    last_max  = f.mx;
                    last_mean = f.mean;
                end
            end
            if (d_done) begin
                if (exp_divs.size() == 0) flag("div_unexpected");
                else begin
                    div_t d;
                    d = exp_divs.pop_front();
                    check("div_quot", 32'(d_quot), 32'(d.q));
                    check("div_latency", cyc, d.due);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        rxd = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    // Sends one frame built from smp[]; stops after 'limit' data bytes when limit < 2N.
    task automatic send_frame(input logic [7:0] h1, input int limit);
        logic [7:0]  db[$];
        longint      sum;
        logic [15:0] mn, mx;
        frame_t      f;
        int          n;
        n = smp.size();
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_bit(1'b0);
        send_byte(HDR0_DEF);
        send_byte(h1);
        if (h1 != HDR1_DEF) begin
            rxd = 1'b1;
            return;
        end
        exp_bytes.push_back(8'(n));
        send_byte(8'(n));
        foreach (smp[i]) begin
            db.push_back(smp[i][7:0]);
            db.push_back(smp[i][15:8]);
        end
        for (int k = 0; k < db.size() && k < limit; k++) begin
            exp_bytes.push_back(db[k]);
            send_byte(db[k]);
        end
        if (limit < db.size() || n == 0) begin
            rxd = 1'b1;
            return;
        end
        sum = 0;
        mn  = 16'hFFFF;
        mx  = 16'h0000;
        foreach (smp[i]) begin
            sum += longint'(smp[i]);
            if (smp[i] < mn) mn = smp[i];
            if (smp[i] > mx) mx = smp[i];
        end
        f.mn   = mn;
        f.mx   = mx;
        f.mean = 16'(sum / n);
        f.due  = cyc + 24;
        exp_frames.push_back(f);
        rxd = 1'b1;
    endtask

    task automatic div_once(input logic [23:0] a, input logic [7:0] b);
        div_t   d;
        longint q;
        q = (b == 0) ? 64'hFFFF : longint'(a) / longint'(b);
        d.q   = (q > 64'hFFFF) ? 16'hFFFF : 16'(q);
        d.due = cyc + 24;
        exp_divs.push_back(d);
        d_dividend = a;
        d_divisor  = b;
        d_start    = 1'b1;
        @(posedge clk);
        #1;
        d_start = 1'b0;
        repeat (27) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_frames.size() != 0 || exp_divs.size() != 0 || exp_bytes.size() != 0) && guard < 80) begin
            @(posedge clk);
            guard++;
        end
        #1;
        if (guard >= 80) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: bytes %0d frames %0d divs %0d still pending, required 0",
                     exp_bytes.size(), exp_frames.size(), exp_divs.size());
            exp_bytes.delete();
            exp_frames.delete();
            exp_divs.delete();
        end
    endtask

    task automatic check_held(input string tag);
        @(negedge clk);
        check({tag, "_min"}, 32'(dist_min), 32'(last_min));
        check({tag, "_max"}, 32'(dist_max), 32'(last_max));
        check({tag, "_mean"}, 32'(dist_mean), 32'(last_mean));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_byte_data", 32'(byte_data), 0);
        check("rst_byte_valid", 32'(byte_valid), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check_held("rst");

        div_once(24'h2BA891, 8'h3A);
        div_once(24'hFFFFFF, 8'h01);
        div_once(24'h123456, 8'h00);
        for (int i = 0; i < 5; i++)
            div_once(24'($urandom), 8'($urandom_range(1, 255)));
        drain();

        smp = '{16'h0100, 16'h0300, 16'h0200};
        send_frame(HDR1_DEF, 1000);
        drain();

        smp = '{16'h1234};
        send_frame(8'hAB, 1000);
        repeat (30) @(posedge clk);
        #1;
        check_held("badhdr");
        smp = '{16'h0010, 16'h0005};
        send_frame(HDR1_DEF, 1000);
        drain();

        smp = '{16'hFFFF};
        send_frame(HDR1_DEF, 1000);
        drain();
        smp = '{16'h0001, 16'h0002};
        send_frame(HDR1_DEF, 1000);
        drain();

        smp.delete();
        send_frame(HDR1_DEF, 1000);
        repeat (30) @(posedge clk);
        #1;
        drain();
        check_held("n0");

        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(1, 12);
            smp.delete();
            for (int i = 0; i < n; i++) smp.push_back(16'($urandom));
            send_frame(HDR1_DEF, 1000);
            drain();
        end

        smp = '{16'h0700, 16'h0050, 16'h9000, 16'h0001};
        send_frame(HDR1_DEF, 3);
        repeat (3) send_bit(1'b1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_pending_bytes", exp_bytes.size(), 0);
        last_min  = '0;
        last_max  = '0;
        last_mean = '0;
        check_held("midrst");
        check("midrst_byte_valid", 32'(byte_valid), 0);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_held("midrst_after");
        smp = '{16'h4000, 16'h0002, 16'h8001};
        send_frame(HDR1_DEF, 1000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lidar_uart_distance.md
Name: lidar_uart_distance

Overview:
- Serial front end for a distance-sensor scan frame: receives a 1-bit-per-clock serial stream and checks the 0x55,0xAA header.
- Parses a sample count plus 16-bit distance samples, and reports minimum, maximum and mean distance per frame.
- The mean is computed by an internal sequential 24/8 divider.
- Sits between the sensor RX pin and the navigation logic.

Parameters:
- HDR0, 8'h55, first header byte.
- HDR1, 8'hAA, second header byte.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  serial data; idle high; one bit per clk.
- byte_data  output  8  last payload byte received.
- byte_valid  output  1  one-cycle strobe, byte_data valid.
- dist_min  output  16  smallest sample of last completed frame.
- dist_max  output  16  largest sample of last completed frame.
- dist_mean  output  16  floor(sum of samples / count) of last frame.
- frame_done  output  1  one-cycle strobe; dist_* updated this cycle.

Behaviour:
- Reset: all outputs 0; receiver in IDLE_WAIT_HIGH; accumulators cleared; divider idle. Reset mid-frame aborts the frame; no frame_done is produced.
- Receiver states:
  - IDLE_WAIT_HIGH: stay until rxd=1 is sampled, then go to IDLE.
  - IDLE: rxd=0 is a start bit; go to HDR. The bit counter is 3 bits.
  - HDR, LSN, DATA: no further start or stop bits. Bytes are contiguous, LSB first, 8 clk per byte.
- Byte assembly: each completed byte is available the cycle after its 8th bit is sampled.
- Header check: byte0 must equal HDR0 and byte1 must equal HDR1.
  - On mismatch, discard and go to IDLE_WAIT_HIGH.
  - No byte_valid is asserted for header bytes.
- Sample count: byte2 = N (sample count, 0..255), emitted on byte_data/byte_valid.
  - N=0: frame ends with no frame_done; outputs unchanged; go to IDLE_WAIT_HIGH.
- DATA: 2N bytes follow, each emitted on byte_valid.
  - Each sample is little-endian: low byte first, then high byte.
  - On each completed sample: min=min(min,s), max=max(max,s), sum+=s (24-bit, cannot overflow), cnt++.
  - min starts at 16'hFFFF, max at 0, sum at 0 for each frame.
- After the Nth sample:
  - Pulse divider start with dividend=sum, divisor=N.
  - Receiver goes to IDLE_WAIT_HIGH and may receive the next frame while dividing.
  - A new frame's sample completion does not disturb the in-flight division; the divider operand is latched at start.
- Divider:
  - Unsigned restoring division, 24-bit dividend / 8-bit divisor, 1 quotient bit per cycle, MSB first.
  - done pulses exactly 24 cycles after the start cycle.
  - Quotient is the low 16 bits; saturates to 16'hFFFF if the upper 8 quotient bits are nonzero. Unreachable here since N≥1 and sum≤255*65535.
  - Divisor 0 yields 16'hFFFF; unreachable from the parser.
  - start while busy is ignored.
- Completion: on divider done, in the same cycle, dist_mean=quotient, dist_min/dist_max take the latched frame values, and frame_done=1 for one cycle.
  - Outputs hold until the next frame_done or reset.

Decomposition:
- Shared package: HDR0/HDR1 defaults, receiver state enum (IDLE_WAIT_HIGH, IDLE, HDR, LSN, DATA), divider width constants (24, 8, 16).
- One natural sub-module: udiv24_8 (ports clk, reset, start, dividend[23:0], divisor[7:0], quotient[15:0], done).
- Receiver and parser stay in the top.

Test Plan:
- udiv24_8 alone: dividend 24'h2BA891, divisor 8'h3A, start pulse -> quotient 16'hC0B3, done exactly 24 cycles later, one cycle wide.
- Frame: idle high, start 0, bytes 55,AA,03,00,01,00,03,00,02 -> byte_valid 7 times (03,00,01,00,03,00,02); frame_done ~25 cycles after last bit; min 0x0100, max 0x0300, mean 0x0200.
- Bad header: start, 55,AB,... -> no byte_valid, no frame_done; then line high and a valid frame -> processed normally.
- Single sample N=1 value 0xFFFF -> min=max=mean=0xFFFF. Samples 1,2 (N=2) -> mean 1 (floor).
- N=0 frame (55,AA,00) -> byte_valid once for 00; no frame_done; outputs unchanged.
- Reset asserted mid-DATA -> all outputs 0, no frame_done; the next complete frame produces correct results.
